// File: rtl/alu_ops_pkg.sv
// Shared decode constants: RV32 opcodes, ALU SELECT codes, immediate formats
// and the decoded bundle carried through the ID/EX skid buffer.
package alu_ops_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_SLL    = 6'b000001;
    localparam logic [5:0] ALU_SLT    = 6'b000010;
    localparam logic [5:0] ALU_SLTU   = 6'b000011;
    localparam logic [5:0] ALU_XOR    = 6'b000100;
    localparam logic [5:0] ALU_SRL    = 6'b000101;
    localparam logic [5:0] ALU_OR     = 6'b000110;
    localparam logic [5:0] ALU_AND    = 6'b000111;
    localparam logic [5:0] ALU_MUL    = 6'b001000;
    localparam logic [5:0] ALU_MULH   = 6'b001001;
    localparam logic [5:0] ALU_MULHSU = 6'b001010;
    localparam logic [5:0] ALU_MULHU  = 6'b001011;
    localparam logic [5:0] ALU_DIV    = 6'b001100;
    localparam logic [5:0] ALU_DIVU   = 6'b001101;
    localparam logic [5:0] ALU_REM    = 6'b001110;
    localparam logic [5:0] ALU_REMU   = 6'b001111;
    localparam logic [5:0] ALU_SUB    = 6'b010000;
    localparam logic [5:0] ALU_SRA    = 6'b010101;
    localparam logic [5:0] ALU_FWD    = 6'b011000;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic [5:0]  alu_select;
        logic        opa_pc;
        logic        opb_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/alu_op_decoder_if.sv
// Instruction-in / decoded-bundle-out handshake bus of the decoder.
// master = fetch/execute environment, slave = decoder.
interface alu_op_decoder_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      alu_select;
    logic            opa_pc;
    logic            opb_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_select, opa_pc, opb_imm, imm,
               rs1, rs2, rd, reg_write, mem_read, mem_write, branch, jump, illegal
    );

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, alu_select, opa_pc, opb_imm, imm,
               rs1, rs2, rd, reg_write, mem_read, mem_write, branch, jump, illegal
    );
endinterface

// File: rtl/alu_op_decoder_imm_gen.sv
// Combinational immediate extraction (I/S/B/U/J) with sign extension to 32 bits.
module imm_gen
    import alu_ops_pkg::*;
(
    input  logic [31:7] instr_bits,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{instr_bits[31]}}, instr_bits[31:20]};
            IMM_S: imm = {{20{instr_bits[31]}}, instr_bits[31:25], instr_bits[11:7]};
            IMM_B: imm = {{19{instr_bits[31]}}, instr_bits[31], instr_bits[7],
                          instr_bits[30:25], instr_bits[11:8], 1'b0};
            IMM_U: imm = {instr_bits[31:12], 12'b0};
            IMM_J: imm = {{11{instr_bits[31]}}, instr_bits[31], instr_bits[19:12],
                          instr_bits[20], instr_bits[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I(M) decoder producing ALU control, registered into a 2-entry skid buffer.
// Build option: define RV32M_DECODE_EN to decode funct7=0000001 on OP as MUL..REMU.
module alu_op_decoder
    import alu_ops_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_decoder_if.slave  bus
);

    localparam int              CNT_W     = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_EMPTY = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SKID_DEPTH);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_type_e   imm_type;
    logic [31:0] imm_val;
    dec_bundle_t dec;

    dec_bundle_t      ent0_reg, ent0_next, ent1_reg, ent1_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             in_ready_reg;
    logic             acc_in, acc_out;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    always_comb begin
        imm_type = IMM_I;
        case (opcode)
            OPC_STORE:           imm_type = IMM_S;
            OPC_BRANCH:          imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:  imm_type = IMM_U;
            OPC_JAL:             imm_type = IMM_J;
            default:             imm_type = IMM_I;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_bits (bus.instr[31:7]),
        .imm_type   (imm_type),
        .imm        (imm_val)
    );

    always_comb begin
        dec            = '0;
        dec.alu_select = ALU_ADD;
        dec.imm        = imm_val;
        dec.rs1        = bus.instr[19:15];
        dec.rs2        = bus.instr[24:20];
        dec.rd         = bus.instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: dec.alu_select = {3'b000, funct3};
                    7'b0100000: begin
                        if (funct3 == 3'b000 || funct3 == 3'b101)
                            dec.alu_select = {3'b010, funct3};
                        else
                            dec.illegal = 1'b1;
                    end
`ifdef RV32M_DECODE_EN
                    7'b0000001: dec.alu_select = {3'b001, funct3};
`endif
                    default:    dec.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.reg_write  = 1'b1;
                dec.opb_imm    = 1'b1;
                dec.alu_select = {3'b000, funct3};
                // Shift-immediates carry a funct7 in imm[11:5]; only SRAI maps to SRA.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (funct3 == 3'b101 && funct7 == 7'b0100000)
                        dec.alu_select = ALU_SRA;
                    else if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                        dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.alu_select = ALU_FWD;
                dec.opb_imm    = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.opa_pc    = 1'b1;
                dec.opb_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.opa_pc    = 1'b1;
                dec.opb_imm   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.opb_imm   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.illegal   = (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                dec.opb_imm   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.illegal   = (funct3 == 3'b011) || (funct3 > 3'b101);
            end
            OPC_STORE: begin
                dec.opb_imm   = 1'b1;
                dec.mem_write = 1'b1;
                dec.illegal   = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec.alu_select = ALU_SUB;
                    2'b10:   dec.alu_select = ALU_SLT;
                    2'b11:   dec.alu_select = ALU_SLTU;
                    default: dec.illegal    = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.alu_select = ALU_ADD;
            dec.opa_pc     = 1'b0;
            dec.opb_imm    = 1'b0;
            dec.reg_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
        end
        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    assign acc_in  = bus.in_valid & in_ready_reg;
    assign acc_out = bus.out_valid & bus.out_ready;

    // Entry 0 always drives the outputs; entry 1 only catches a stalled input.
    always_comb begin
        ent0_next  = ent0_reg;
        ent1_next  = ent1_reg;
        count_next = count_reg;
        if (bus.flush) begin
            count_next = CNT_EMPTY;
        end else begin
            case (count_reg)
                CNT_EMPTY: begin
                    if (acc_in) begin
                        ent0_next  = dec;
                        count_next = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (acc_in && acc_out) begin
                        ent0_next = dec;
                    end else if (acc_in) begin
                        ent1_next  = dec;
                        count_next = CNT_FULL;
                    end else if (acc_out) begin
                        count_next = CNT_EMPTY;
                    end
                end
                default: begin
                    if (acc_out) begin
                        ent0_next  = ent1_reg;
                        count_next = CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_reg     <= '0;
            ent1_reg     <= '0;
            count_reg    <= CNT_EMPTY;
            in_ready_reg <= 1'b0;
        end else begin
            ent0_reg     <= ent0_next;
            ent1_reg     <= ent1_next;
            count_reg    <= count_next;
            in_ready_reg <= (count_next < CNT_FULL);
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = (count_reg != CNT_EMPTY);
    assign bus.alu_select = ent0_reg.alu_select;
    assign bus.opa_pc     = ent0_reg.opa_pc;
    assign bus.opb_imm    = ent0_reg.opb_imm;
    assign bus.imm        = XLEN'($signed(ent0_reg.imm));
    assign bus.rs1        = ent0_reg.rs1;
    assign bus.rs2        = ent0_reg.rs2;
    assign bus.rd         = ent0_reg.rd;
    assign bus.reg_write  = ent0_reg.reg_write;
    assign bus.mem_read   = ent0_reg.mem_read;
    assign bus.mem_write  = ent0_reg.mem_write;
    assign bus.branch     = ent0_reg.branch;
    assign bus.jump       = ent0_reg.jump;
    assign bus.illegal    = ent0_reg.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: directed instructions push expected
// bundles; a negedge monitor pops and compares on every output transfer.
module tb_alu_op_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_decoder_if #(.XLEN(32)) bus ();

    alu_op_decoder #(.XLEN(32), .SKID_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [5:0]  sel;
        logic        opa;
        logic        opb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  flags;   // {reg_write, mem_read, mem_write, branch, jump, illegal}
    } exp_t;

    typedef struct {
        exp_t e;
        logic care_imm;
    } sb_t;

    localparam logic [5:0] F_RW  = 6'b100000;
    localparam logic [5:0] F_MR  = 6'b010000;
    localparam logic [5:0] F_MW  = 6'b001000;
    localparam logic [5:0] F_BR  = 6'b000100;
    localparam logic [5:0] F_ILL = 6'b000001;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_out    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t a;
        sb_t  s;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            a.sel   = bus.alu_select;
            a.opa   = bus.opa_pc;
            a.opb   = bus.opb_imm;
            a.imm   = bus.imm;
            a.rs1   = bus.rs1;
            a.rs2   = bus.rs2;
            a.rd    = bus.rd;
            a.flags = {bus.reg_write, bus.mem_read, bus.mem_write,
                       bus.branch, bus.jump, bus.illegal};
            $display("out %0d sel=%b opa=%b opb=%b imm=0x%08h rd=%0d flags=%b",
                     n_out, a.sel, a.opa, a.opb, a.imm, a.rd, a.flags);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bundle: got 0x%0h required none", a);
            end else begin
                s = sb_q.pop_front();
                if (!s.care_imm) begin
                    a.imm   = '0;
                    s.e.imm = '0;
                end
                check($sformatf("bundle_%0d", n_out), 64'(a), 64'(s.e));
            end
            n_out++;
        end
    end

    task automatic send(input logic [31:0] w, input exp_t e, input logic care, input logic expect_out);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 required 1 (instr 0x%08h)", w);
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_out)
            sb_q.push_back('{e: e, care_imm: care});
        $display("in  instr=0x%08h expect_out=%0d", w, expect_out);
        step();
    endtask

    task automatic send_v(input logic [31:0] w, input logic [5:0] sel, input logic opa,
                          input logic opb, input logic [31:0] imm, input logic [5:0] flags,
                          input logic care);
        exp_t e;
        e.sel   = sel;
        e.opa   = opa;
        e.opb   = opb;
        e.imm   = imm;
        e.rs1   = w[19:15];
        e.rs2   = w[24:20];
        e.rd    = w[11:7];
        e.flags = flags;
        send(w, e, care, 1'b1);
    endtask

    task automatic send_drop(input logic [31:0] w);
        send(w, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int v;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(bus.in_ready),   64'(0));
        check("rst_out_valid",  64'(bus.out_valid),  64'(0));
        check("rst_alu_select", 64'(bus.alu_select), 64'(0));
        check("rst_imm",        64'(bus.imm),        64'(0));
        check("rst_reg_write",  64'(bus.reg_write),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("in_ready_after_reset", 64'(bus.in_ready), 64'(1));

        // ADD x3,x1,x2 on an empty buffer: visible the cycle after acceptance
        send_v(32'h002081B3, 6'b000000, 1'b0, 1'b0, 32'h0, F_RW, 1'b0);
        bus.in_valid = 1'b0;
        check("latency_out_valid", 64'(bus.out_valid), 64'(1));
        step();

        send_v(32'h402081B3, 6'b010000, 1'b0, 1'b0, 32'h0,        F_RW, 1'b0);  // SUB
        send_v(32'hFFF00093, 6'b000000, 1'b0, 1'b1, 32'hFFFFFFFF, F_RW, 1'b1);  // ADDI x1,x0,-1
`ifdef RV32M_DECODE_EN
        send_v(32'h027302B3, 6'b001000, 1'b0, 1'b0, 32'h0, F_RW,  1'b0);        // MUL
`else
        send_v(32'h027302B3, 6'b000000, 1'b0, 1'b0, 32'h0, F_ILL, 1'b0);        // MUL illegal
`endif
        send_v(32'h123450B7, 6'b011000, 1'b0, 1'b1, 32'h12345000, F_RW, 1'b1);  // LUI x1
        send_v(32'h12345037, 6'b011000, 1'b0, 1'b1, 32'h12345000, 6'b0, 1'b1);  // LUI x0
        send_v(32'h4041D113, 6'b010101, 1'b0, 1'b1, 32'h00000404, F_RW, 1'b1);  // SRAI x2,x3,4
        send_v(32'h02011093, 6'b000000, 1'b0, 1'b0, 32'h0, F_ILL, 1'b0);        // SLLI bad imm[11:5]
        send_v(32'h00209463, 6'b010000, 1'b0, 1'b0, 32'h00000008, F_BR, 1'b1);  // BNE +8
        send_v(32'h0020C463, 6'b000010, 1'b0, 1'b0, 32'h00000008, F_BR, 1'b1);  // BLT +8
        send_v(32'h0020F463, 6'b000011, 1'b0, 1'b0, 32'h00000008, F_BR, 1'b1);  // BGEU +8
        send_v(32'h0020A623, 6'b000000, 1'b0, 1'b1, 32'h0000000C, F_MW, 1'b1);  // SW x2,12(x1)
        send_v(32'hFFC0A203, 6'b000000, 1'b0, 1'b1, 32'hFFFFFFFC, F_RW | F_MR, 1'b1); // LW x4,-4(x1)
        send_v(32'h00001297, 6'b000000, 1'b1, 1'b1, 32'h00001000, F_RW, 1'b1);  // AUIPC x5,1
        bus.in_valid = 1'b0;
        repeat (3) step();

        // Four back-to-back instructions with the execute stage stalled for 3 cycles
        bus.out_ready = 1'b0;
        fork
            begin
                send_v(32'h00100093, 6'b000000, 1'b0, 1'b1, 32'd1, F_RW, 1'b1);
                send_v(32'h00200113, 6'b000000, 1'b0, 1'b1, 32'd2, F_RW, 1'b1);
                send_v(32'h00300193, 6'b000000, 1'b0, 1'b1, 32'd3, F_RW, 1'b1);
                send_v(32'h00400213, 6'b000000, 1'b0, 1'b1, 32'd4, F_RW, 1'b1);
            end
            begin
                repeat (3) step();
                check("stall_in_ready_full", 64'(bus.in_ready), 64'(0));
                bus.out_ready = 1'b1;
                v = 0;
                repeat (4) begin
                    @(negedge clk);
                    v += int'(bus.out_valid);
                end
                check("stream_valid_cycles", 64'(v), 64'(4));
            end
        join
        bus.in_valid = 1'b0;
        repeat (3) step();

        // FLUSH with both entries full and an input offered in the same cycle
        bus.out_ready = 1'b0;
        send_drop(32'h00500293);
        send_drop(32'h00600313);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00700393;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_full_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_full_in_ready",  64'(bus.in_ready),  64'(1));
        bus.out_ready = 1'b1;
        repeat (4) step();

        // FLUSH with one entry while a new input is actually accepted
        bus.out_ready = 1'b0;
        send_drop(32'h00800413);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00900493;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_one_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_one_in_ready",  64'(bus.in_ready),  64'(1));
        bus.out_ready = 1'b1;
        repeat (4) step();

        // Decoder resumes normally after a flush
        send_v(32'h002081B3, 6'b000000, 1'b0, 1'b0, 32'h0, F_RW, 1'b0);
        bus.in_valid = 1'b0;

        v = 0;
        while (sb_q.size() != 0 && v < 50) begin
            step();
            v++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
